// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect request,
// IF/ID handshake toward decode and the stop status flags.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        br_taken;
    logic [31:0] br_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus8;
    logic        halted;
    logic        fault;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  br_taken,
        input  br_target,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_pc_plus8,
        output halted,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output br_taken,
        output br_target,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus8,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures memory words into the IF/ID
// register, handles redirects, and stops at the image end or on a bad target.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_RUN     | fetching sequentially, one capture per accepted slot
// ST_HALTED  | last word captured; waits for a legal redirect
// ST_FAULTED | illegal redirect seen; only reset recovers
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam logic [31:0] LAST = 32'(MEM_WORDS * 4 - 4);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_FAULTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        valid, valid_nxt;
    logic [31:0] instr, instr_nxt;
    logic [31:0] ipc, ipc_nxt;
    logic        cap;
    logic        target_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            valid <= 1'b0;
            instr <= 32'h0;
            ipc   <= 32'h0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            valid <= valid_nxt;
            instr <= instr_nxt;
            ipc   <= ipc_nxt;
        end
    end

    assign cap       = !valid || bus.if_ready;
    assign target_ok = (bus.br_target[1:0] == 2'b00) && (bus.br_target <= LAST);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        valid_nxt = valid;
        instr_nxt = instr;
        ipc_nxt   = ipc;

        // A faulted fetch ignores redirects entirely; everywhere else they flush.
        if (bus.br_taken && state != ST_FAULTED) begin
            valid_nxt = 1'b0;
            if (target_ok) begin
                pc_nxt    = bus.br_target;
                state_nxt = ST_RUN;
            end else begin
                state_nxt = ST_FAULTED;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (cap) begin
                        instr_nxt = bus.imem_instr;
                        ipc_nxt   = pc;
                        valid_nxt = 1'b1;
                        if (pc == LAST) begin
                            state_nxt = ST_HALTED;
                        end else begin
                            pc_nxt = pc + 32'd4;
                        end
                    end
                end
                ST_HALTED, ST_FAULTED: begin
                    if (bus.if_ready) begin
                        valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = ST_FAULTED;
                end
            endcase
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_valid    = valid;
    assign bus.if_instr    = instr;
    assign bus.if_pc       = ipc;
    assign bus.if_pc_plus8 = ipc + 32'd8;
    assign bus.halted      = (state == ST_HALTED);
    assign bus.fault       = (state == ST_FAULTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all
// compared every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam int          MEM_WORDS = 64;
    localparam logic [31:0] LAST      = 32'(MEM_WORDS * 4 - 4);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    logic [31:0] mem [MEM_WORDS];
    assign bus.imem_instr = (bus.imem_addr <= LAST) ? mem[bus.imem_addr[7:2]] : 32'hDEAD_BEEF;

    int checks   = 0;
    int failures = 0;

    // model: 0 = fetching, 1 = stopped at image end, 2 = stopped on bad target
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit legal;
        if (!rst_n) begin
            m_mode = 0; m_pc = 32'h0; m_valid = 0; m_instr = 32'h0; m_ipc = 32'h0;
        end else if (bus.br_taken && m_mode != 2) begin
            legal   = (bus.br_target % 4 == 0) && (bus.br_target <= LAST);
            m_valid = 0;
            if (legal) begin
                m_pc   = bus.br_target;
                m_mode = 0;
            end else begin
                m_mode = 2;
            end
        end else if (m_mode == 0) begin
            if (!m_valid || bus.if_ready) begin
                m_instr = mem[m_pc / 4];
                m_ipc   = m_pc;
                m_valid = 1;
                if (m_pc == LAST) m_mode = 1;
                else              m_pc   = m_pc + 4;
            end
        end else if (bus.if_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("imem_addr",   bus.imem_addr,   m_pc);
        check("if_valid",    32'(bus.if_valid), 32'(m_valid));
        check("if_instr",    bus.if_instr,    m_instr);
        check("if_pc",       bus.if_pc,       m_ipc);
        check("if_pc_plus8", bus.if_pc_plus8, m_ipc + 32'd8);
        check("halted",      32'(bus.halted), 32'(m_mode == 1));
        check("fault",       32'(bus.fault),  32'(m_mode == 2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0; bus.if_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic run_until_pc(input logic [31:0] target);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_pc == target) found = 1;
            else step();
        end
        if (!found) check("pc_reach_timeout", 32'(m_pc), target);
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.br_taken = 1'b1; bus.br_target = target;
        step();
        bus.br_taken = 1'b0;
    endtask

    logic [31:0] bad_targets [2];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        rst_n = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0; bus.if_ready = 1'b1;

        // reset and sequential run
        do_reset();
        check("reset_plus8", bus.if_pc_plus8, 32'd8);
        step();
        check("first_valid", 32'(bus.if_valid), 32'd1);
        check("first_pc", bus.if_pc, 32'h0);
        for (int i = 0; i < 3; i++) step();

        // stall with if_pc = 0x10
        bus.if_ready = 1'b1;
        run_until_pc(32'h14);
        check("stall_pc_before", bus.if_pc, 32'h10);
        bus.if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_pc", bus.if_pc, 32'h10);
            check("stall_addr", bus.imem_addr, 32'h14);
        end
        bus.if_ready = 1'b1;
        step();
        check("stall_resume", bus.if_pc, 32'h14);

        // redirect with decode ready, then with decode stalled
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            run_until_pc(32'h0C);
            bus.if_ready = (pass == 0);
            redirect(32'h40);
            check("redir_bubble", 32'(bus.if_valid), 32'd0);
            bus.if_ready = 1'b1;
            step();
            check("redir_target", bus.if_pc, 32'h40);
            step();
        end

        // end of image, drain, then recover
        do_reset();
        run_until_pc(LAST);
        step();
        check("last_pc", bus.if_pc, LAST);
        check("last_halted", 32'(bus.halted), 32'd1);
        step();
        check("drained", 32'(bus.if_valid), 32'd0);
        step();
        redirect(32'h0);
        check("unhalt", 32'(bus.halted), 32'd0);
        step();
        check("resume_zero", bus.if_pc, 32'h0);

        // redirect coincident with halt entry
        run_until_pc(LAST);
        redirect(32'h8);
        check("coinc_no_halt", 32'(bus.halted), 32'd0);
        step();
        check("coinc_target", bus.if_pc, 32'h8);

        // illegal redirects
        bad_targets[0] = 32'h42;
        bad_targets[1] = 32'h100;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 4; i++) step();
            redirect(bad_targets[k]);
            check("bad_fault", 32'(bus.fault), 32'd1);
            for (int i = 0; i < 3; i++) step();
            redirect(32'h20);
            check("fault_sticky", 32'(bus.fault), 32'd1);
            step();
            check("fault_no_fetch", 32'(bus.if_valid), 32'd0);
        end

        // reset during a stall with valid data
        do_reset();
        for (int i = 0; i < 3; i++) step();
        bus.if_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        check("midrst_valid", 32'(bus.if_valid), 32'd0);
        check("midrst_pc", bus.imem_addr, 32'h0);
        rst_n = 1'b1;
        bus.if_ready = 1'b1;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int sel;
            rst_n        = ($urandom_range(0, 199) != 0);
            bus.if_ready = ($urandom_range(0, 3) != 0);
            bus.br_taken = ($urandom_range(0, 24) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)       bus.br_target = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
            else if (sel == 7) bus.br_target = (32'($urandom_range(0, MEM_WORDS - 1)) * 4) | 32'($urandom_range(1, 3));
            else if (sel == 8) bus.br_target = LAST + 4 + 32'($urandom_range(0, 255)) * 4;
            else               bus.br_target = LAST;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
